// File: rtl/mem_burst_reader.sv
// -----------------------------------------------------------------------------
// mem_burst_reader
//   Read-side initiator for a word-addressed memory with an
//   enable/readwrite/address/datain/dataout port. A start command launches
//   sequential reads over [start_addr, start_addr+burst_len-1]. Each word is
//   pushed, with its address, into a small FIFO. The FIFO drains through a
//   valid/ready output so a slow consumer stalls the reads, not the data.
//
// Ports
//   clk, reset       single clock, synchronous active-high reset
//   start            command strobe, only looked at in IDLE
//   start_addr       first word address (latched on the accepted start)
//   burst_len        word count (latched on the accepted start), 0 = empty burst
//   busy             high in ISSUE, DRAIN and FINISH
//   done             one-cycle pulse in FINISH
//   out_valid/out_ready/out_data/out_addr   FIFO head stream
//   mem_enable/mem_readwrite/mem_address/mem_datain/mem_dataout  memory port
//   dbg_state        current FSM state, for observation only
//
// Handshake: a word moves on out_* in every cycle where out_valid & out_ready
// are both high at the rising edge. Once out_valid is high, it and the head
// data/address stay put until that transfer happens.
// -----------------------------------------------------------------------------
module mem_burst_reader #(
   parameter int ADDR_W     = 16,
   parameter int DATA_W     = 32,
   parameter int FIFO_DEPTH = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [ADDR_W-1:0] start_addr,
   input  logic [ADDR_W-1:0] burst_len,
   output logic              busy,
   output logic              done,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [ADDR_W-1:0] out_addr,
   output logic              mem_enable,
   output logic              mem_readwrite,
   output logic [ADDR_W-1:0] mem_address,
   output logic [DATA_W-1:0] mem_datain,
   input  logic [DATA_W-1:0] mem_dataout,
   output logic [1:0]        dbg_state
);

   localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ISSUE  = 2'd1,
      DRAIN  = 2'd2,
      FINISH = 2'd3
   } state_t;

   state_t state_q, state_d;

   logic [ADDR_W-1:0] cur_addr;
   logic [ADDR_W-1:0] remaining;
   logic [ADDR_W-1:0] last_addr;

   logic [DATA_W-1:0] fifo_data [FIFO_DEPTH];
   logic [ADDR_W-1:0] fifo_addr [FIFO_DEPTH];
   logic [PTR_W-1:0]  wr_ptr, rd_ptr;
   logic [CNT_W-1:0]  count, count_next;

   logic issue;
   logic pop;

   // Full check uses the registered count only: a pop in the same cycle does
   // not free a slot for a read until the next cycle.
   assign issue     = (state_q == ISSUE) && (count < DEPTH_C);
   assign out_valid = (count != '0);
   assign pop       = out_valid && out_ready;

   always_comb begin
      count_next = count;
      case ({issue, pop})
         2'b10:   count_next = count + 1'b1;
         2'b01:   count_next = count - 1'b1;
         default: count_next = count;
      endcase
   end

   // ---------------------------------------------------------------- FSM
   always_ff @(posedge clk) begin
      if (reset) state_q <= IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (start) state_d = (burst_len == '0) ? FINISH : ISSUE;
         end
         ISSUE: begin
            if (issue && (remaining == ADDR_W'(1))) state_d = DRAIN;
         end
         // Leave DRAIN on the cycle the last word is popped so done lands
         // in the cycle right after it leaves the FIFO.
         DRAIN: begin
            if (count_next == '0) state_d = FINISH;
         end
         FINISH: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // ------------------------------------------------------- datapath regs
   always_ff @(posedge clk) begin
      if (reset) begin
         cur_addr  <= '0;
         remaining <= '0;
         last_addr <= '0;
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         count     <= '0;
      end else begin
         if (state_q == IDLE && start) begin
            cur_addr  <= start_addr;
            remaining <= burst_len;
         end
         if (issue) begin
            cur_addr          <= cur_addr + 1'b1;  // wraps modulo 2^ADDR_W
            remaining         <= remaining - 1'b1;
            last_addr         <= cur_addr;
            fifo_data[wr_ptr] <= mem_dataout;
            fifo_addr[wr_ptr] <= cur_addr;
            wr_ptr            <= wr_ptr + 1'b1;
         end
         if (pop) rd_ptr <= rd_ptr + 1'b1;
         count <= count_next;
      end
   end

   // ------------------------------------------------------------ outputs
   // The FIFO storage is not reset; the head is masked to zero when empty.
   assign out_data      = out_valid ? fifo_data[rd_ptr] : '0;
   assign out_addr      = out_valid ? fifo_addr[rd_ptr] : '0;

   assign mem_enable    = issue;
   assign mem_readwrite = issue;
   assign mem_address   = issue ? cur_addr : last_addr;
   assign mem_datain    = '0;

   assign busy          = (state_q != IDLE);
   assign done          = (state_q == FINISH);
   assign dbg_state     = state_q;

endmodule
